// File: rtl/data_mem_sram.sv
// Byte-enabled word RAM behind the memory controller, with optional wait states.
// Define DMEM_TOHOST_EN to enable the tohost capture port at TOHOST_ADDR.
module data_mem_sram #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_address,
  input  logic        i_read_enable,
  input  logic        i_write_enable,
  input  logic [31:0] i_write_data,
  input  logic [3:0]  i_byte_enables,
  output logic [31:0] o_read_data,
  output logic        o_rsp_valid,
  output logic        o_err,
  output logic        o_busy,
  output logic [31:0] o_tohost_data,
  output logic        o_tohost_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT =
    3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
`ifdef DMEM_TOHOST_EN
  localparam bit TH_EN = 1'b1;
`else
  localparam bit TH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_cap;
  logic        r_cap_err;
  logic        r_cap_tv;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_tv;
  logic [31:0] r_tohost;

  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_th;
  logic          w_acc;
  logic          w_err;
  logic          w_thw;
  logic [31:0]   w_rd;
  logic [31:0]   w_mask;
  logic          w_unused_addr;

  assign w_idx  = i_address[AW+1:2];
  assign w_oor  = |i_address[31:AW+2];
  assign w_th   = TH_EN && (i_address[31:2] == TOHOST_ADDR[31:2]);
  assign w_acc  = (r_state != S_WAIT) &&
                  (i_read_enable || i_write_enable);
  assign w_err  = w_oor && !w_th;
  assign w_thw  = w_th && i_write_enable;
  assign w_mask = {{8{i_byte_enables[3]}}, {8{i_byte_enables[2]}},
                   {8{i_byte_enables[1]}}, {8{i_byte_enables[0]}}};
  assign w_unused_addr = &{1'b0, i_address[1:0]};

  // Read path sees the pre-write word: read-before-write on the same edge.
  always_comb begin
    w_rd = r_mem[w_idx];
    if (w_th)
      w_rd = r_tohost;
    else if (w_oor)
      w_rd = '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (!w_acc)
          w_next = S_IDLE;
        else if (WAIT_STATES == 0)
          w_next = S_RESP;
        else
          w_next = S_WAIT;
      end
      S_WAIT: if (r_cnt == 3'd0) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cap     <= '0;
      r_cap_err <= 1'b0;
      r_cap_tv  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tv      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        if (WAIT_STATES == 0) begin
          r_rdata <= w_rd;
          r_err   <= w_err;
          r_tv    <= w_thw;
        end else begin
          r_cap     <= w_rd;
          r_cap_err <= w_err;
          r_cap_tv  <= w_thw;
          r_cnt     <= CNT_INIT;
        end
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        // Output word only moves when a response is issued.
        if (r_cnt == 3'd0) begin
          r_rdata <= r_cap;
          r_err   <= r_cap_err;
          r_tv    <= r_cap_tv;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_acc && i_write_enable && !w_oor && !w_th) begin
      for (int i = 0; i < 4; i++) begin
        if (i_byte_enables[i])
          r_mem[w_idx][8*i +: 8] <= i_write_data[8*i +: 8];
      end
    end
  end

`ifdef DMEM_TOHOST_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_tohost <= '0;
    else if (w_acc && w_thw)
      r_tohost <= i_write_data & w_mask;
  end
  assign o_tohost_data  = r_tohost;
  assign o_tohost_valid = (r_state == S_RESP) && r_tv;
`else
  assign r_tohost       = '0;
  assign o_tohost_data  = '0;
  assign o_tohost_valid = 1'b0 & r_tv & (&w_mask);
`endif

  assign o_read_data = r_rdata;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_err       = (r_state == S_RESP) && r_err;
  assign o_busy      = (r_state == S_WAIT);

endmodule
